// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Before the core runs, a host or UART
// byte source streams the program in. This block packs the bytes little-endian
// into WIDTH-bit words and writes them to consecutive word addresses starting
// at 0. The core is held in reset for the whole load.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous reset, active-high
//   i_start      one-cycle load request, only looked at while idle
//   i_numWords   number of words to load, sampled with i_start, clamped to DEPTH
//   i_abort      cancels a load in progress and flags an error
//   i_byteIn     stream data byte
//   i_byteValid  i_byteIn carries a byte
//   o_byteReady  a byte is accepted this cycle when valid and ready are both high
//   o_we         memory write enable, one pulse per assembled word
//   o_waddr      memory word address, meaningful only while o_we is high
//   o_wdata      assembled word, meaningful only while o_we is high
//   o_busy       load in progress
//   o_cpuHold    keeps the core in reset, same as o_busy
//   o_done       last load completed, held until the next accepted start
//   o_error      last load was aborted, held until the next accepted start
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [AW:0]      i_numWords,
    input  logic             i_abort,
    input  logic [7:0]       i_byteIn,
    input  logic             i_byteValid,
    output logic             o_byteReady,
    output logic             o_we,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_busy,
    output logic             o_cpuHold,
    output logic             o_done,
    output logic             o_error
);

    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int NB_MINUS_1 = NB - 1;
    localparam logic [BW-1:0] LAST_BYTE = NB_MINUS_1[BW-1:0];
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] ONE_W = 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FINISH
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [AW:0]      r_count;
    logic [AW:0]      r_wordCnt;
    logic [BW-1:0]    r_byteCnt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_lastData;
    logic [AW-1:0]    r_lastAddr;
    logic             r_done;
    logic             r_error;

    logic [AW:0]      w_clampedCount;
    logic [AW:0]      w_wordCntInc;
    logic             w_transfer;
    logic             w_lastByte;
    logic             w_lastWord;

    // A request for more words than the memory holds is trimmed to the memory
    // size, which is why the write address can never wrap past DEPTH-1.
    always_comb begin
        w_clampedCount = i_numWords;
        if (i_numWords > DEPTH_W) begin
            w_clampedCount = DEPTH_W;
        end
    end

    // The byte lane counter picks which lane of the word the next byte fills;
    // the word counter doubles as the write address for the current word.
    assign w_lastByte   = (r_byteCnt == LAST_BYTE);
    assign w_wordCntInc = r_wordCnt + ONE_W;
    assign w_lastWord   = (w_wordCntInc == r_count);

    // State register for the load sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode. An abort while loading wins over a byte
    // transfer or a memory write in the same cycle, so ready and write enable
    // are simply never raised while abort is high in those states.
    always_comb begin
        w_nextState = r_state;
        o_byteReady = 1'b0;
        o_we        = 1'b0;
        w_transfer  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = (w_clampedCount == '0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else begin
                    o_byteReady = 1'b1;
                    w_transfer  = i_byteValid;
                    if (i_byteValid && w_lastByte) begin
                        w_nextState = WRITE;
                    end
                end
            end
            WRITE: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else begin
                    o_we        = 1'b1;
                    w_nextState = w_lastWord ? FINISH : COLLECT;
                end
            end
            FINISH: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: counters, byte packing, the last-written address/data and the
    // done/error flags. The flags are levels that survive until the next
    // accepted start so the host can read the outcome at leisure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_wordCnt  <= '0;
            r_byteCnt  <= '0;
            r_word     <= '0;
            r_lastData <= '0;
            r_lastAddr <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_count   <= w_clampedCount;
                        r_wordCnt <= '0;
                        r_byteCnt <= '0;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (i_abort) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b0;
                    end else if (w_transfer) begin
                        for (int k = 0; k < NB; k++) begin
                            if (int'(r_byteCnt) == k) begin
                                r_word[8*k +: 8] <= i_byteIn;
                            end
                        end
                        if (!w_lastByte) begin
                            r_byteCnt <= r_byteCnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (i_abort) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_lastAddr <= r_wordCnt[AW-1:0];
                        r_lastData <= r_word;
                        r_wordCnt  <= w_wordCntInc;
                        r_byteCnt  <= '0;
                    end
                end
                FINISH: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // During the write cycle the live word and address are presented; at all
    // other times the outputs keep showing the most recent completed write.
    assign o_waddr   = (r_state == WRITE) ? r_wordCnt[AW-1:0] : r_lastAddr;
    assign o_wdata   = (r_state == WRITE) ? r_word : r_lastData;
    assign o_busy    = (r_state == COLLECT) || (r_state == WRITE);
    assign o_cpuHold = o_busy;
    assign o_done    = r_done;
    assign o_error   = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A table of load scenarios (word count,
// inter-byte gap, abort point, stray start point, expected outcome) is applied
// one by one, followed by randomized scenarios and a reset-during-load sequence.
// Expected memory writes come from the byte stream itself: word i is bytes
// 4i..4i+3 read little-endian, written to address i.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 32;
    localparam int AW = 10;
    localparam int NB = 4;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [AW:0]      i_numWords;
    logic             i_abort;
    logic [7:0]       i_byteIn;
    logic             i_byteValid;
    logic             o_byteReady;
    logic             o_we;
    logic [AW-1:0]    o_waddr;
    logic [WIDTH-1:0] o_wdata;
    logic             o_busy;
    logic             o_cpuHold;
    logic             o_done;
    logic             o_error;

    typedef struct {
        int numWords;
        int gap;
        int abortAfter;
        int midStartAt;
        int expWrites;
        int expDone;
        int expError;
    } loadVec_t;

    loadVec_t    vecs[$];
    logic [7:0]  streamBuf[$];
    int          wrAddr[$];
    logic [31:0] wrData[$];
    logic [7:0]  prog [16] = '{8'h97, 8'h01, 8'h00, 8'h10, 8'h83, 8'ha3, 8'h01, 8'h00,
                               8'h13, 8'h84, 8'h81, 8'h00, 8'h93, 8'h84, 8'h41, 8'h00};

    int vectors = 0;
    int miscompares = 0;
    int holdViol = 0;
    int readyViol = 0;
    bit holdSeen = 0;
    bit monEn = 0;

    imem_loader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_numWords  (i_numWords),
        .i_abort     (i_abort),
        .i_byteIn    (i_byteIn),
        .i_byteValid (i_byteValid),
        .o_byteReady (o_byteReady),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy),
        .o_cpuHold   (o_cpuHold),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case the design wedges somewhere the bounded waits miss.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Passive monitor on the falling edge: records every memory write and
    // tracks the cpu-hold and ready/write-enable relationships during a load.
    always @(negedge i_clk) begin
        if (o_we) begin
            wrAddr.push_back(int'(o_waddr));
            wrData.push_back(o_wdata);
        end
        if (o_cpuHold) holdSeen = 1'b1;
        if (o_cpuHold !== o_busy) holdViol++;
        if (monEn && o_busy && (o_byteReady === o_we)) readyViol++;
    end

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All outputs must read zero after reset.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_byteReady"}, o_byteReady, 0);
        checkOutput({tag, "_we"}, o_we, 0);
        checkOutput({tag, "_waddr"}, o_waddr, 0);
        checkOutput({tag, "_wdata"}, o_wdata, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_cpuHold"}, o_cpuHold, 0);
        checkOutput({tag, "_done"}, o_done, 0);
        checkOutput({tag, "_error"}, o_error, 0);
    endtask

    // Offer one byte and hold it until the loader takes it, with a cycle bound.
    task automatic sendByte(input logic [7:0] b, output bit ok);
        bit rdy;
        ok = 1'b0;
        i_byteIn = b;
        i_byteValid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_clk);
            rdy = o_byteReady;
            @(posedge i_clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        i_byteValid = 1'b0;
    endtask

    // Reference: how many words reach memory for a given load.
    function automatic int modelWrites(input int nw, input int abortAfter);
        if (abortAfter >= 0) begin
            return (abortAfter % NB == 0) ? abortAfter / NB - 1 : abortAfter / NB;
        end
        return (nw > DEPTH) ? DEPTH : nw;
    endfunction

    // Run one complete load scenario and compare the outcome with the model.
    task automatic applyStimulus(input loadVec_t v);
        int nBytes;
        int sent;
        int g;
        int bad;
        bit ok;
        bit finished;
        logic [31:0] expWord;
        streamBuf.delete();
        wrAddr.delete();
        wrData.delete();
        holdSeen = 1'b0;
        holdViol = 0;
        readyViol = 0;
        nBytes = ((v.numWords > DEPTH) ? DEPTH : v.numWords) * NB;
        for (int i = 0; i < nBytes; i++) begin
            streamBuf.push_back((i < 16) ? prog[i] : 8'($urandom));
        end
        monEn = (v.abortAfter < 0);
        i_numWords = 11'(v.numWords);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (v.numWords == 0) begin
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput("zeroLoadDoneTwoCyclesLater", o_done, 1);
        end
        sent = 0;
        while (sent < nBytes) begin
            g = (v.gap < 0) ? int'($urandom_range(0, 2)) : v.gap;
            repeat (g) begin
                @(posedge i_clk);
                #1;
            end
            sendByte(streamBuf[sent], ok);
            if (!ok) begin
                checkOutput("byteAccepted", ok, 1);
                break;
            end
            sent++;
            if (sent == v.abortAfter) begin
                i_abort = 1'b1;
                i_byteValid = 1'b1;
                i_byteIn = 8'hee;
                @(negedge i_clk);
                checkOutput("readyDuringAbort", o_byteReady, 0);
                checkOutput("weDuringAbort", o_we, 0);
                @(posedge i_clk);
                #1;
                i_abort = 1'b0;
                i_byteValid = 1'b0;
                break;
            end
            if (sent == v.midStartAt) begin
                i_numWords = 11'd3;
                i_start = 1'b1;
                @(posedge i_clk);
                #1;
                i_start = 1'b0;
            end
        end
        finished = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_clk);
            if (!o_busy && (o_done || o_error)) begin
                finished = 1'b1;
                break;
            end
        end
        checkOutput("loadFinished", finished, 1);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("writeCount", wrAddr.size(), v.expWrites);
        bad = 0;
        for (int i = 0; i < wrAddr.size() && i < v.expWrites; i++) begin
            expWord = {streamBuf[4*i+3], streamBuf[4*i+2], streamBuf[4*i+1], streamBuf[4*i]};
            if (wrAddr[i] != i || wrData[i] !== expWord) begin
                if (bad == 0) begin
                    $display("[TB] first bad write #%0d: addr %0d data %h, model addr %0d data %h",
                             i, wrAddr[i], wrData[i], i, expWord);
                end
                bad++;
            end
        end
        checkOutput("writeAddrData", bad, 0);
        if (v.expWrites > 0 && wrAddr.size() > 0) begin
            checkOutput("lastWaddr", wrAddr[wrAddr.size()-1], v.expWrites - 1);
        end
        checkOutput("done", o_done, v.expDone);
        checkOutput("error", o_error, v.expError);
        checkOutput("busyAfter", o_busy, 0);
        checkOutput("cpuHoldTracksBusy", holdViol, 0);
        checkOutput("cpuHoldSeen", holdSeen, (v.numWords != 0) ? 1 : 0);
        if (monEn) begin
            checkOutput("readyLowOnlyInWrite", readyViol, 0);
        end
    endtask

    initial begin
        loadVec_t rv;
        int readyHigh;
        bit ok;

        i_rst = 1'b1;
        i_start = 1'b0;
        i_numWords = '0;
        i_abort = 1'b0;
        i_byteIn = '0;
        i_byteValid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkResetState("powerOn");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // numWords, gap, abortAfter, midStartAt, expWrites, expDone, expError
        vecs.push_back(loadVec_t'{4, 0, -1, -1, 4, 1, 0});
        vecs.push_back(loadVec_t'{4, 3, -1, -1, 4, 1, 0});
        vecs.push_back(loadVec_t'{0, 0, -1, -1, 0, 1, 0});
        vecs.push_back(loadVec_t'{4, 0, 6, -1, 1, 0, 1});
        vecs.push_back(loadVec_t'{2, 1, -1, -1, 2, 1, 0});
        vecs.push_back(loadVec_t'{3, 0, 8, -1, 1, 0, 1});
        vecs.push_back(loadVec_t'{1, 0, -1, -1, 1, 1, 0});
        vecs.push_back(loadVec_t'{2000, 0, -1, 100, 1024, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            $display("[TB] table scenario %0d: %0d words", i, vecs[i].numWords);
            applyStimulus(vecs[i]);
            if (i == 0 && wrData.size() >= 4) begin
                checkOutput("progWord0", wrData[0], 32'h10000197);
                checkOutput("progWord1", wrData[1], 32'h0001a383);
                checkOutput("progWord2", wrData[2], 32'h00818413);
                checkOutput("progWord3", wrData[3], 32'h00418493);
            end
        end

        for (int r = 0; r < 8; r++) begin
            rv.numWords = int'($urandom_range(1, 10));
            rv.gap = -1;
            rv.midStartAt = -1;
            rv.abortAfter = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, rv.numWords * NB)) : -1;
            rv.expWrites = modelWrites(rv.numWords, rv.abortAfter);
            rv.expDone = (rv.abortAfter < 0) ? 1 : 0;
            rv.expError = (rv.abortAfter < 0) ? 0 : 1;
            $display("[TB] random scenario %0d: %0d words, abort after %0d", r, rv.numWords, rv.abortAfter);
            applyStimulus(rv);
        end

        $display("[TB] reset during third word");
        streamBuf.delete();
        wrAddr.delete();
        wrData.delete();
        monEn = 1'b0;
        for (int i = 0; i < 16; i++) streamBuf.push_back(prog[i]);
        i_numWords = 11'd4;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sendByte(streamBuf[i], ok);
            if (!ok) checkOutput("rstTestByteAccepted", ok, 1);
        end
        i_rst = 1'b1;
        i_byteValid = 1'b1;
        i_byteIn = streamBuf[9];
        @(posedge i_clk);
        @(negedge i_clk);
        checkResetState("midLoadReset");
        checkOutput("writesBeforeReset", wrAddr.size(), 2);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        readyHigh = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_byteReady) readyHigh++;
        end
        i_byteValid = 1'b0;
        checkOutput("readyAfterReset", readyHigh, 0);
        checkOutput("writesAfterReset", wrAddr.size(), 2);
        checkOutput("busyAfterReset", o_busy, 0);

        $display("[TB] fresh load after reset");
        applyStimulus(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
